// File: rtl/conv_encoder_k7_if.sv
// Stream interface for the K=7 convolutional encoder: information-bit input
// handshake plus code-pair output handshake with tail/last framing flags.
interface conv_encoder_k7_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] tx_pair;
  logic       out_tail;
  logic       out_last;

  // Source of information bits and sink of code pairs
  modport master (
    output in_valid, in_bit, out_ready,
    input  in_ready, out_valid, tx_pair, out_tail, out_last
  );

  // Encoder side
  modport slave (
    input  in_valid, in_bit, out_ready,
    output in_ready, out_valid, tx_pair, out_tail, out_last
  );
endinterface

// File: rtl/conv_encoder_k7.sv
// Rate-1/2, constraint-length-7 convolutional encoder with automatic
// zero-tail termination after BLOCK_LEN information bits per frame.
// tx_pair[0] uses G0, tx_pair[1] uses G1; the MSB of each generator taps the
// current input bit and sr[5] holds the most recent previous bit.
module conv_encoder_k7 #(
  parameter int unsigned    K         = 7,
  parameter logic [K-1:0]   G0        = 7'o171,
  parameter logic [K-1:0]   G1        = 7'o133,
  parameter int unsigned    BLOCK_LEN = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               abort,
  conv_encoder_k7_if.slave   bus,
  output logic [K-2:0]       enc_state
);

  localparam int unsigned    CntW     = $clog2(BLOCK_LEN + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(BLOCK_LEN - 1);
  localparam logic [2:0]     LastTail = 3'(K - 2);

  typedef enum logic [1:0] {StIdle, StData, StTail} state_e;

  state_e          state_q, state_d;
  logic [K-2:0]    sr_q, sr_d;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]      tail_cnt_q, tail_cnt_d;
  logic            out_valid_q, out_valid_d;
  logic [1:0]      tx_pair_q, tx_pair_d;
  logic            out_tail_q, out_tail_d;
  logic            out_last_q, out_last_d;

  logic            can_load, accept, tail_gen, load, enc_bit, last_tail;
  logic [K-1:0]    full;
  logic [1:0]      pair;

  assign can_load     = !out_valid_q || bus.out_ready;
  assign bus.in_ready = can_load && (state_q != StTail) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign tail_gen     = can_load && (state_q == StTail);
  assign load         = accept || tail_gen;
  // Tail cycles never accept, so the encoded bit is forced to zero there
  assign enc_bit      = accept ? bus.in_bit : 1'b0;
  assign full         = {enc_bit, sr_q};
  assign pair         = {^(full & G1), ^(full & G0)};
  assign last_tail    = tail_gen && (tail_cnt_q == LastTail);

  assign bus.out_valid = out_valid_q;
  assign bus.tx_pair   = tx_pair_q;
  assign bus.out_tail  = out_tail_q;
  assign bus.out_last  = out_last_q;
  assign enc_state     = sr_q;

  // Frame FSM, shift register and output stage next-state; abort wins over all
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    tail_cnt_d  = tail_cnt_q;
    out_valid_d = out_valid_q;
    tx_pair_d   = tx_pair_q;
    out_tail_d  = out_tail_q;
    out_last_d  = out_last_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (BLOCK_LEN == 1) begin
            state_d    = StTail;
            bit_cnt_d  = '0;
            tail_cnt_d = '0;
          end else begin
            state_d   = StData;
            bit_cnt_d = CntW'(1);
          end
        end
      end
      StData: begin
        if (accept) begin
          if (bit_cnt_q == LastCnt) begin
            state_d    = StTail;
            bit_cnt_d  = '0;
            tail_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StTail: begin
        if (tail_gen) begin
          tail_cnt_d = tail_cnt_q + 1'b1;
          if (last_tail) begin
            state_d    = StIdle;
            tail_cnt_d = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      sr_d        = {enc_bit, sr_q[K-2:1]};
      out_valid_d = 1'b1;
      tx_pair_d   = pair;
      out_tail_d  = tail_gen;
      out_last_d  = last_tail;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (abort) begin
      state_d     = StIdle;
      sr_d        = '0;
      bit_cnt_d   = '0;
      tail_cnt_d  = '0;
      out_valid_d = 1'b0;
      tx_pair_d   = '0;
      out_tail_d  = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      tail_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      tx_pair_q   <= '0;
      out_tail_q  <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      tail_cnt_q  <= tail_cnt_d;
      out_valid_q <= out_valid_d;
      tx_pair_q   <= tx_pair_d;
      out_tail_q  <= out_tail_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_conv_encoder_k7.sv
// Self-checking bench for conv_encoder_k7. Three instances (BLOCK_LEN 4, 1, 64)
// are driven cycle by cycle; every fired pair is compared against a reference
// built by direct convolution of the frame bits with the generator taps.
module tb_conv_encoder_k7;

  localparam logic [6:0] G0 = 7'o171;
  localparam logic [6:0] G1 = 7'o133;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;
  int nrdy0   = 0;

  logic       iv [3];
  logic       ib [3];
  logic       ordy [3];
  logic       ab [3];
  logic       ov [3];
  logic       ir [3];
  logic       tl [3];
  logic       ls [3];
  logic [1:0] tp [3];
  logic [5:0] es [3];
  logic       acc [3];
  bit         sb_en [3];
  int         first_fire [3];
  int         last_fire [3];

  bit         in_q  [3][$];
  logic [3:0] exp_q [3][$];
  logic [3:0] obs_q [3][$];

  bit         fb [$];
  logic [3:0] fe [$];

  logic [1:0] imp_pairs [10] = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b00,
                                 2'b10, 2'b11, 2'b00, 2'b00, 2'b00};

  conv_encoder_k7_if ifa ();
  conv_encoder_k7_if ifb ();
  conv_encoder_k7_if ifc ();

  assign ifa.in_valid = iv[0];
  assign ifa.in_bit = ib[0];
  assign ifa.out_ready = ordy[0];
  assign ifb.in_valid = iv[1];
  assign ifb.in_bit = ib[1];
  assign ifb.out_ready = ordy[1];
  assign ifc.in_valid = iv[2];
  assign ifc.in_bit = ib[2];
  assign ifc.out_ready = ordy[2];

  assign ov[0] = ifa.out_valid;
  assign ir[0] = ifa.in_ready;
  assign tp[0] = ifa.tx_pair;
  assign tl[0] = ifa.out_tail;
  assign ls[0] = ifa.out_last;
  assign ov[1] = ifb.out_valid;
  assign ir[1] = ifb.in_ready;
  assign tp[1] = ifb.tx_pair;
  assign tl[1] = ifb.out_tail;
  assign ls[1] = ifb.out_last;
  assign ov[2] = ifc.out_valid;
  assign ir[2] = ifc.in_ready;
  assign tp[2] = ifc.tx_pair;
  assign tl[2] = ifc.out_tail;
  assign ls[2] = ifc.out_last;

  conv_encoder_k7 #(.BLOCK_LEN(4)) dut_a (
    .clk(clk), .rst(rst), .abort(ab[0]), .bus(ifa), .enc_state(es[0])
  );
  conv_encoder_k7 #(.BLOCK_LEN(1)) dut_b (
    .clk(clk), .rst(rst), .abort(ab[1]), .bus(ifb), .enc_state(es[1])
  );
  conv_encoder_k7 #(.BLOCK_LEN(64)) dut_c (
    .clk(clk), .rst(rst), .abort(ab[2]), .bus(ifc), .enc_state(es[2])
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: each output j is the GF(2) convolution of the zero-tailed
  // frame with the generator taps; tap 6 multiplies the current bit.
  task automatic build_frame();
    int  len;
    int  n;
    bit  ub;
    bit  p0;
    bit  p1;
    len = fb.size();
    n = len + 6;
    fe.delete();
    for (int j = 0; j < n; j++) begin
      p0 = 1'b0;
      p1 = 1'b0;
      for (int m = 0; m < 7; m++) begin
        ub = (j - m >= 0 && j - m < len) ? fb[j-m] : 1'b0;
        p0 = p0 ^ (ub & G0[6-m]);
        p1 = p1 ^ (ub & G1[6-m]);
      end
      fe.push_back({(j == n - 1), (j >= len), p1, p0});
    end
  endtask

  task automatic add_frame(input int i);
    build_frame();
    foreach (fb[k]) in_q[i].push_back(fb[k]);
    foreach (fe[k]) exp_q[i].push_back(fe[k]);
  endtask

  task automatic rand_frame(input int len);
    fb.delete();
    for (int k = 0; k < len; k++) fb.push_back(1'($urandom_range(0, 1)));
  endtask

  // Called at a negedge with inputs already set; samples, then waits one cycle
  task automatic cycle();
    logic [3:0] e;
    #1;
    if (!ir[0]) nrdy0++;
    for (int i = 0; i < 3; i++) begin
      acc[i] = iv[i] && ir[i];
      if (ov[i] && ordy[i]) begin
        obs_q[i].push_back({ls[i], tl[i], tp[i]});
        if (first_fire[i] < 0) first_fire[i] = cyc_n;
        last_fire[i] = cyc_n;
        if (sb_en[i]) begin
          check_eq($sformatf("sb_has_entry_dut%0d", i), 32'(exp_q[i].size() > 0), 1);
          if (exp_q[i].size() > 0) begin
            e = exp_q[i].pop_front();
            check_eq($sformatf("pair_dut%0d{last,tail,pair}", i),
                     32'({ls[i], tl[i], tp[i]}), 32'(e));
          end
        end
      end
    end
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic run(input int i, input bit rnd, input int budget);
    int n;
    n = 0;
    while ((in_q[i].size() > 0 || exp_q[i].size() > 0) && n < budget) begin
      iv[i]   = (in_q[i].size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
      ib[i]   = (in_q[i].size() > 0) ? in_q[i][0] : 1'b0;
      ordy[i] = !rnd || ($urandom_range(0, 3) != 0);
      cycle();
      if (acc[i]) void'(in_q[i].pop_front());
      n++;
    end
    iv[i]   = 1'b0;
    ordy[i] = 1'b1;
    check_eq($sformatf("drained_dut%0d", i), exp_q[i].size() + in_q[i].size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    logic [1:0] hold;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ib[i] = 1'b0; ordy[i] = 1'b1; ab[i] = 1'b0; acc[i] = 1'b0;
      sb_en[i] = 1'b1; first_fire[i] = -1; last_fire[i] = -1;
    end

    // Reset state
    #2;
    check_eq("rst_out_valid", 32'(ov[0]), 0);
    check_eq("rst_tx_pair", 32'(tp[0]), 0);
    check_eq("rst_out_tail", 32'(tl[0]), 0);
    check_eq("rst_out_last", 32'(ls[0]), 0);
    check_eq("rst_in_ready", 32'(ir[0]), 0);
    check_eq("rst_enc_state", 32'(es[0]), 0);
    @(negedge clk);
    rst = 1'b0;

    // Impulse frame against the literal golden sequence
    fb = {1'b1, 1'b0, 1'b0, 1'b0};
    add_frame(0);
    obs_q[0].delete();
    nrdy0 = 0;
    run(0, 1'b0, 40);
    check_eq("imp_count", obs_q[0].size(), 10);
    for (int k = 0; k < 10 && k < obs_q[0].size(); k++) begin
      check_eq($sformatf("imp_pair%0d", k), 32'(obs_q[0][k][1:0]), 32'(imp_pairs[k]));
      check_eq($sformatf("imp_tail%0d", k), 32'(obs_q[0][k][2]), 32'(k >= 4));
      check_eq($sformatf("imp_last%0d", k), 32'(obs_q[0][k][3]), 32'(k == 9));
    end
    check_eq("imp_tail_not_ready", nrdy0, 6);
    check_eq("imp_end_state", 32'(es[0]), 0);

    // Random frames with random valid/ready
    for (int f = 0; f < 8; f++) begin
      rand_frame(4);
      add_frame(0);
    end
    run(0, 1'b1, 2000);
    check_eq("rand_end_state", 32'(es[0]), 0);

    // Backpressure: 5-cycle stall after two accepts
    rand_frame(4);
    add_frame(0);
    for (int k = 0; k < 2; k++) begin
      iv[0] = 1'b1; ib[0] = in_q[0][0]; ordy[0] = 1'b1;
      cycle();
      check_eq("bp_pre_accept", 32'(acc[0]), 1);
      if (acc[0]) void'(in_q[0].pop_front());
    end
    hold = tp[0];
    for (int s = 0; s < 5; s++) begin
      iv[0] = 1'b1; ib[0] = in_q[0][0]; ordy[0] = 1'b0;
      cycle();
      check_eq("bp_no_accept", 32'(acc[0]), 0);
      check_eq("bp_out_valid", 32'(ov[0]), 1);
      check_eq("bp_pair_stable", 32'(tp[0]), 32'(hold));
      check_eq("bp_in_ready", 32'(ir[0]), 0);
    end
    run(0, 1'b0, 100);

    // Abort on the third tail cycle
    sb_en[0] = 1'b0;
    fb = {1'b1, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 4; k++) begin
      iv[0] = 1'b1; ib[0] = fb[k]; ordy[0] = 1'b1;
      cycle();
      check_eq("ab_accept", 32'(acc[0]), 1);
    end
    iv[0] = 1'b0;
    cycle();
    check_eq("ab_tail_not_ready", 32'(ir[0]), 0);
    cycle();
    ab[0] = 1'b1;
    cycle();
    ab[0] = 1'b0;
    #1;
    check_eq("ab_out_valid", 32'(ov[0]), 0);
    check_eq("ab_enc_state", 32'(es[0]), 0);
    check_eq("ab_in_ready", 32'(ir[0]), 1);
    in_q[0].delete(); exp_q[0].delete(); obs_q[0].delete();
    sb_en[0] = 1'b1;
    fb = {1'b1, 1'b0, 1'b0, 1'b0};
    add_frame(0);
    run(0, 1'b0, 40);
    check_eq("ab_first_pair", (obs_q[0].size() > 0) ? 32'(obs_q[0][0][1:0]) : -1, 3);

    // Asynchronous reset mid-DATA
    sb_en[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      iv[0] = 1'b1; ib[0] = 1'b1; ordy[0] = 1'b1;
      cycle();
    end
    iv[0] = 1'b0;
    check_eq("rst2_pre_valid", 32'(ov[0]), 1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst2_out_valid", 32'(ov[0]), 0);
    check_eq("rst2_tx_pair", 32'(tp[0]), 0);
    check_eq("rst2_enc_state", 32'(es[0]), 0);
    check_eq("rst2_in_ready", 32'(ir[0]), 0);
    #1 rst = 1'b0;
    @(negedge clk);
    in_q[0].delete(); exp_q[0].delete(); obs_q[0].delete();
    sb_en[0] = 1'b1;
    rand_frame(4);
    add_frame(0);
    rand_frame(4);
    add_frame(0);
    run(0, 1'b1, 300);

    // BLOCK_LEN=1 back-to-back frames, no bubbles
    for (int f = 0; f < 5; f++) begin
      rand_frame(1);
      add_frame(1);
    end
    obs_q[1].delete();
    first_fire[1] = -1;
    run(1, 1'b0, 100);
    check_eq("b2b_pairs", obs_q[1].size(), 35);
    check_eq("b2b_span", last_fire[1] - first_fire[1] + 1, 35);
    check_eq("b2b_end_state", 32'(es[1]), 0);

    // BLOCK_LEN=64 all ones: pairs 7..64 are 11
    fb.delete();
    for (int k = 0; k < 64; k++) fb.push_back(1'b1);
    add_frame(2);
    obs_q[2].delete();
    run(2, 1'b0, 300);
    bad = 0;
    for (int k = 6; k < 64 && k < obs_q[2].size(); k++)
      if (obs_q[2][k][1:0] != 2'b11) bad++;
    check_eq("ones_count", obs_q[2].size(), 70);
    check_eq("ones_steady_not11", bad, 0);
    check_eq("ones_end_state", 32'(es[2]), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
